// File: rtl/cpu32_multicycle.sv
// Multicycle 32-bit CPU (IF/ID/EX/MEM/WB) with req/ready instruction and data memory ports.
// Define CPU32_MC_PERF_EN to add the cycle_count / instr_count performance counters.
module cpu32_multicycle #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal
`ifdef CPU32_MC_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
`endif
);

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010,
                         OP_ORI  = 6'b010000, OP_AND = 6'b010001, OP_OR   = 6'b010010,
                         OP_SLT  = 6'b011011, OP_SW  = 6'b100110, OP_LW   = 6'b100111,
                         OP_BEQ  = 6'b110000, OP_BNE = 6'b110001, OP_HALT = 6'b111111;

  typedef enum logic [2:0] {ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_HALT} state_t;
  state_t state, nextState;

  logic [31:0]       ir, regA, regB, ext, aluOut, mdr, aluRes;
  logic [31:0]       rf [32];
  logic [ADDR_W-1:0] npc, brTarget;
  logic              illegalQ;
  logic [5:0]        op;
  logic [4:0]        rs, rt, rd, dest;
  logic              isRType, isBranch, isLoad, isStore, isMem, isHalt, isTrap;
  logic              brTaken, misaligned;

  // Single shared ALU; immediate forms use the pre-extended EXT operand.
  function automatic logic [31:0] aluCalc(input logic [5:0] opc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (opc)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_ORI:  return a | imm;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      default: return a + imm;
    endcase
  endfunction

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign isRType  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
  assign isBranch = op inside {OP_BEQ, OP_BNE};
  assign isLoad   = (op == OP_LW);
  assign isStore  = (op == OP_SW);
  assign isMem    = isLoad | isStore;
  assign isHalt   = (op == OP_HALT);
  assign isTrap   = !(isRType | isBranch | isMem | isHalt | (op == OP_ADDI) | (op == OP_ORI));
  assign dest     = isRType ? rd : rt;

  assign aluRes     = aluCalc(op, regA, regB, ext);
  assign misaligned = (aluRes[1:0] != 2'b00);
  assign brTaken    = (op == OP_BEQ) ? (regA == regB) : (regA != regB);
  assign brTarget   = npc + ADDR_W'({ext[29:0], 2'b00});

  assign imem_addr  = pc;
  assign dmem_addr  = aluOut[ADDR_W-1:0];
  assign dmem_wdata = regB;
  assign illegal    = illegalQ;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= ST_IF;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IF:   if (imem_ready) nextState = ST_ID;
      ST_ID:   nextState = (isHalt || isTrap) ? ST_HALT : ST_EX;
      ST_EX: begin
        if (isBranch)   nextState = ST_IF;
        else if (isMem) nextState = misaligned ? ST_HALT : ST_MEM;
        else            nextState = ST_WB;
      end
      ST_MEM:  if (dmem_ready) nextState = isStore ? ST_IF : ST_WB;
      ST_WB:   nextState = ST_IF;
      default: nextState = ST_HALT;
    endcase
  end

  // Requests are gated by Reset so an in-flight transfer is dropped immediately.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_IF:   imem_req = !Reset;
      ST_EX:   retire   = isBranch;
      ST_MEM: begin
        dmem_req = !Reset;
        dmem_we  = isStore;
        retire   = isStore && dmem_ready;
      end
      ST_WB:   retire   = 1'b1;
      ST_HALT: halted   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc       <= RESET_PC;
      npc      <= '0;
      ir       <= '0;
      regA     <= '0;
      regB     <= '0;
      ext      <= '0;
      aluOut   <= '0;
      mdr      <= '0;
      illegalQ <= 1'b0;
    end else begin
      case (state)
        ST_IF: if (imem_ready) begin
          ir  <= imem_rdata;
          npc <= pc + ADDR_W'(4);
        end
        ST_ID: begin
          regA <= rf[rs];
          regB <= rf[rt];
          ext  <= (op == OP_ORI) ? {16'b0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
          if (isTrap) illegalQ <= 1'b1;
        end
        ST_EX: begin
          aluOut <= aluRes;
          if (isBranch)                pc       <= brTaken ? brTarget : npc;
          else if (isMem && misaligned) illegalQ <= 1'b1;
        end
        ST_MEM: if (dmem_ready) begin
          if (isStore) pc  <= npc;
          else         mdr <= dmem_rdata;
        end
        ST_WB:   pc <= npc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == ST_WB && dest != 5'd0) begin
      rf[dest] <= isLoad ? mdr : aluOut;
    end
  end

`ifdef CPU32_MC_PERF_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu32_multicycle.sv
// Bench for cpu32_multicycle: memory responders with wait states plus an ISA-level reference model.
module tb_cpu32_multicycle;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010,
                         OP_ORI = 6'b010000, OP_AND = 6'b010001, OP_OR  = 6'b010010,
                         OP_SLT = 6'b011011, OP_SW  = 6'b100110, OP_LW  = 6'b100111,
                         OP_BEQ = 6'b110000, OP_BNE = 6'b110001, OP_HALT = 6'b111111;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
`ifdef CPU32_MC_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  cpu32_multicycle #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
`ifdef CPU32_MC_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 CLK = ~CLK;

  logic [31:0] prog [64];
  logic [31:0] dmemArr [64];
  logic [31:0] mMem [64];
  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  int  nChecks = 0, nPass = 0;
  int  iDelay = 0, dDelay = 0, iWait = 0, dWait = 0;
  logic idleReady = 1'b0;
  logic active = 1'b0;
  int  runCyc, retires, instrCyc, waits, dReqLen, lastReqLen, dAccesses;
  logic [31:0] lastStAddr, lastStData, lastRetirePc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] iT(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
    return {o, 5'(s), 5'(t), imm};
  endfunction

  function automatic logic [31:0] rT(input logic [5:0] o, input int s, input int t, input int d);
    return {o, 5'(s), 5'(t), 5'(d), 11'b0};
  endfunction

  // Architectural model: executes the instruction at mPc in one step.
  task automatic modelStep();
    logic [31:0] ins, a, b, sx, zx, npc, ea;
    logic [4:0] rs, rt, rd;
    ins = prog[mPc[7:2]];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a = mRegs[rs]; b = mRegs[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'b0, ins[15:0]};
    ea = a + sx;
    npc = mPc + 32'd4;
    case (ins[31:26])
      OP_ADD:  if (rd != 0) mRegs[rd] = a + b;
      OP_SUB:  if (rd != 0) mRegs[rd] = a - b;
      OP_AND:  if (rd != 0) mRegs[rd] = a & b;
      OP_OR:   if (rd != 0) mRegs[rd] = a | b;
      OP_SLT:  if (rd != 0) mRegs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_ADDI: if (rt != 0) mRegs[rt] = a + sx;
      OP_ORI:  if (rt != 0) mRegs[rt] = a | zx;
      OP_SW:   mMem[ea[7:2]] = b;
      OP_LW:   if (rt != 0) mRegs[rt] = mMem[ea[7:2]];
      OP_BEQ:  if (a == b) npc = npc + (sx << 2);
      OP_BNE:  if (a != b) npc = npc + (sx << 2);
      default: check("spurious_retire", 32'd1, 32'd0);
    endcase
    mPc = npc;
  endtask

  task automatic monitorCycle();
    logic [31:0] ins, ea;
    int base;
    ins = prog[mPc[7:2]];
    if (!halted) runCyc++;
    instrCyc++;
    if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) waits++;
    check("pc", pc, mPc);
    if (imem_req) check("imem_addr", imem_addr, mPc);
    if (dmem_req) begin
      ea = mRegs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
      dReqLen++;
      check("dmem_addr", dmem_addr, ea);
      check("dmem_we", {31'b0, dmem_we}, {31'b0, ins[31:26] == OP_SW});
      if (ins[31:26] == OP_SW) check("dmem_wdata", dmem_wdata, mRegs[ins[20:16]]);
      if (dmem_ready) begin
        check("dmem_req_len", dReqLen, dDelay + 1);
        lastReqLen = dReqLen;
        dReqLen = 0;
        dAccesses++;
        if (dmem_we) begin
          lastStAddr = dmem_addr;
          lastStData = dmem_wdata;
        end
      end
    end
    if (retire) begin
      base = (ins[31:26] inside {OP_BEQ, OP_BNE}) ? 3 : (ins[31:26] == OP_LW) ? 5 : 4;
      check("latency", instrCyc, base + waits);
      lastRetirePc = mPc;
      modelStep();
      retires++;
      instrCyc = 0;
      waits = 0;
    end
  endtask

  // Memory responders drive ready/data on the falling edge, then the cycle is checked.
  initial begin : env
    imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (imem_req) begin
        imem_rdata = prog[imem_addr[7:2]];
        imem_ready = (iWait >= iDelay);
        iWait = imem_ready ? 0 : iWait + 1;
      end else begin
        imem_ready = idleReady; imem_rdata = 32'hFFFF_FFFF; iWait = 0;
      end
      if (dmem_req) begin
        dmem_ready = (dWait >= dDelay);
        dWait = dmem_ready ? 0 : dWait + 1;
        dmem_rdata = 32'hFFFF_FFFF;
        if (dmem_ready) begin
          if (dmem_we) dmemArr[dmem_addr[7:2]] = dmem_wdata;
          else         dmem_rdata = dmemArr[dmem_addr[7:2]];
        end
      end else begin
        dmem_ready = idleReady; dmem_rdata = 32'hFFFF_FFFF; dWait = 0;
      end
      #1;
      if (active) monitorCycle();
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 64; i++) begin
      prog[i] = '0;
      dmemArr[i] = '0;
    end
  endtask

  task automatic loadProg1();
    clearMem();
    prog[0] = iT(OP_ADDI, 0, 1, 16'd5);
    prog[1] = iT(OP_ADDI, 0, 2, 16'd7);
    prog[2] = rT(OP_ADD, 1, 2, 3);
    prog[3] = {OP_HALT, 26'b0};
  endtask

  task automatic runProg(input int maxCyc, input int iD, input int dD, input logic idle);
    active = 1'b0;
    Reset = 1'b1;
    iDelay = iD; dDelay = dD; idleReady = idle;
    mPc = 32'h0;
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    for (int i = 0; i < 64; i++) mMem[i] = dmemArr[i];
    runCyc = 0; retires = 0; instrCyc = 0; waits = 0; dReqLen = 0; lastReqLen = 0; dAccesses = 0;
    lastStAddr = '0; lastStData = '0; lastRetirePc = '1;
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    active = 1'b1;
    for (int i = 0; i < maxCyc && !halted; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    #2;
  endtask

  task automatic finalChecks();
    check("halted", {31'b0, halted}, 32'd1);
    check("illegal", {31'b0, illegal}, {31'b0, prog[mPc[7:2]][31:26] != OP_HALT});
    check("pc_frozen", pc, mPc);
    check("retire_low", {31'b0, retire}, 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("r%0d", i), dut.rf[i], mRegs[i]);
  endtask

  initial begin : main
    // Basic ALU program, zero-wait memories; stray ready while idle must be ignored.
    loadProg1();
    runProg(200, 0, 0, 1'b1);
    finalChecks();
    check("p1_r3", dut.rf[3], 32'd12);
    check("p1_illegal", {31'b0, illegal}, 32'd0);
    check("p1_retires", retires, 32'd3);
    check("p1_cycles", runCyc, 32'd14);
`ifdef CPU32_MC_PERF_EN
    check("perf_instr", instr_count, 32'd3);
    check("perf_cycle", cycle_count, 32'd14);
`endif

    // Store then load with three data wait states.
    clearMem();
    prog[0] = iT(OP_ADDI, 0, 1, 16'd5);
    prog[1] = iT(OP_ADDI, 0, 2, 16'd7);
    prog[2] = rT(OP_ADD, 1, 2, 3);
    prog[3] = iT(OP_SW, 0, 3, 16'd8);
    prog[4] = iT(OP_LW, 0, 4, 16'd8);
    prog[5] = {OP_HALT, 26'b0};
    runProg(300, 0, 3, 1'b0);
    finalChecks();
    check("p2_st_addr", lastStAddr, 32'd8);
    check("p2_st_data", lastStData, 32'd12);
    check("p2_mem2", dmemArr[2], 32'd12);
    check("p2_r4", dut.rf[4], 32'd12);
    check("p2_req_len", lastReqLen, 32'd4);
    check("p2_accesses", dAccesses, 32'd2);

    // Mixed ALU ops and branches with one fetch wait state.
    clearMem();
    prog[0]  = iT(OP_ADDI, 0, 1, 16'hFFFD);
    prog[1]  = iT(OP_ORI, 0, 2, 16'h8001);
    prog[2]  = rT(OP_SUB, 1, 2, 3);
    prog[3]  = rT(OP_SLT, 1, 2, 4);
    prog[4]  = iT(OP_BNE, 4, 4, 16'd5);
    prog[5]  = rT(OP_AND, 1, 2, 5);
    prog[6]  = rT(OP_OR, 1, 2, 6);
    prog[7]  = rT(OP_SLT, 2, 1, 7);
    prog[8]  = iT(OP_BEQ, 0, 0, 16'd1);
    prog[9]  = iT(OP_ADDI, 0, 8, 16'd1);
    prog[10] = {OP_HALT, 26'b0};
    runProg(300, 1, 0, 1'b1);
    finalChecks();
    check("p4_r2_zext", dut.rf[2], 32'h0000_8001);
    check("p4_r3_sub", dut.rf[3], 32'hFFFF_7FFC);
    check("p4_r4_slt", dut.rf[4], 32'd1);
    check("p4_r5_and", dut.rf[5], 32'h0000_8001);
    check("p4_r6_or", dut.rf[6], 32'hFFFF_FFFD);
    check("p4_r7_slt", dut.rf[7], 32'd0);
    check("p4_r8_skip", dut.rf[8], 32'd0);
    check("p4_pc", pc, 32'h28);

    // Self-loop branch at 0x10.
    clearMem();
    prog[0] = iT(OP_ADDI, 0, 1, 16'd5);
    prog[4] = iT(OP_BEQ, 1, 1, 16'hFFFF);
    runProg(45, 0, 0, 1'b0);
    check("loop_halted", {31'b0, halted}, 32'd0);
    check("loop_pc", pc, 32'h10);
    check("loop_last_retire", lastRetirePc, 32'h10);

    // Unknown opcode traps.
    clearMem();
    prog[0] = iT(OP_ADDI, 0, 1, 16'd1);
    prog[1] = {6'h3A, 26'b0};
    runProg(100, 0, 0, 1'b0);
    finalChecks();
    check("trap_illegal", {31'b0, illegal}, 32'd1);
    check("trap_pc", pc, 32'h4);

    // Misaligned load traps without touching memory or registers.
    clearMem();
    dmemArr[1] = 32'h55;
    prog[0] = iT(OP_ADDI, 0, 1, 16'd1);
    prog[1] = iT(OP_LW, 0, 2, 16'd6);
    runProg(100, 0, 0, 1'b0);
    finalChecks();
    check("mis_illegal", {31'b0, illegal}, 32'd1);
    check("mis_pc", pc, 32'h4);
    check("mis_r2", dut.rf[2], 32'd0);
    check("mis_accesses", dAccesses, 32'd0);

    // Reset asserted mid-fetch while the instruction memory is stalled.
    loadProg1();
    active = 1'b0;
    iDelay = 0;
    idleReady = 1'b1;
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 100 && pc != 32'h8; i++) begin
      @(posedge CLK);
      #1;
    end
    iDelay = 1000;
    check("mid_pc_before", pc, 32'h8);
    repeat (3) @(negedge CLK);
    #2;
    check("mid_req_before", {31'b0, imem_req}, 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_req_drop", {31'b0, imem_req}, 32'd0);
    check("mid_pc_reset", pc, 32'h0);
    check("mid_halted", {31'b0, halted}, 32'd0);
    check("mid_retire", {31'b0, retire}, 32'd0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    iDelay = 0;
    #1;
    check("mid_req_restart", {31'b0, imem_req}, 32'd1);
    check("mid_addr_restart", imem_addr, 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
